// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one uart_tx serializer
// between N_REQ valid/ready byte-stream requesters. The grant is locked for a
// whole packet, and each byte waits for the serializer's tx_done before the
// next one is fetched. A granted requester that stalls mid-packet for
// STALL_MAX cycles has its packet aborted (STALL_MAX = 0 disables this).
//
// Optional feature macro: UART_ARB_CHECKSUM_EN
//   defined   - after the last byte of each completed packet, one extra byte
//               equal to the XOR of all packet bytes is sent (CSUM/CWAIT).
//   undefined - a packet ends at the last byte's tx_done.

module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int STALL_MAX = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_dv,
  output logic [7:0]         tx_byte,
  input  logic               tx_done,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               err_timeout
);

  localparam int PW = $clog2(N_REQ);
  // One extra bit when the timeout is disabled keeps the counter legal.
  localparam int SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);
  // Pointer starts at the top requester so requester 0 wins first.
  localparam logic [PW-1:0] PTR_RST   = PW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2
`ifdef UART_ARB_CHECKSUM_EN
    ,
    S_CSUM  = 3'd3,
    S_CWAIT = 3'd4
`endif
  } state_t;

  // Running packet checksum: plain XOR fold of every accepted byte.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t           state_r, state_nxt;
  logic [PW-1:0]    ptr_r, ptr_nxt;
  logic [N_REQ-1:0] grant_r, grant_nxt;
  logic             tx_dv_r, tx_dv_nxt;
  logic [7:0]       tx_byte_r, tx_byte_nxt;
  logic             last_r, last_nxt;
  logic [7:0]       csum_r, csum_nxt;
  logic [SW-1:0]    stall_r, stall_nxt;
  logic             busy_r;
  logic             err_r, err_nxt;
  logic [N_REQ-1:0] ready_s;
  logic             win_found_s;
  logic [PW-1:0]    win_idx_s;
  logic [7:0]       cur_byte_s;

  // Byte offered by the currently granted requester (ptr always names the owner).
  assign cur_byte_s = req_data[{ptr_r, 3'b000} +: 8];

  // Round-robin search: first valid requester starting at ptr+1, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = ptr_r;
    for (int i = 1; i <= N_REQ; i++) begin
      logic [PW-1:0] cand_v;
      cand_v = PW'((int'(ptr_r) + i) % N_REQ);
      if (!win_found_s && req_valid[cand_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and datapath decisions for the arbitration FSM.
  always_comb begin
    state_nxt   = state_r;
    ptr_nxt     = ptr_r;
    grant_nxt   = grant_r;
    tx_dv_nxt   = 1'b0;
    tx_byte_nxt = tx_byte_r;
    last_nxt    = last_r;
    csum_nxt    = csum_r;
    stall_nxt   = stall_r;
    err_nxt     = 1'b0;
    ready_s     = '0;
    case (state_r)
      S_IDLE: begin
        if (win_found_s) begin
          state_nxt = S_FETCH;
          ptr_nxt   = win_idx_s;
          grant_nxt = onehot(win_idx_s);
          csum_nxt  = 8'h00;
          stall_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (req_valid[ptr_r]) begin
          ready_s     = onehot(ptr_r);
          tx_byte_nxt = cur_byte_s;
          tx_dv_nxt   = 1'b1;
          last_nxt    = req_last[ptr_r];
          csum_nxt    = csum_add(csum_r, cur_byte_s);
          stall_nxt   = '0;
          state_nxt   = S_WAIT;
        end else if (STALL_MAX != 0) begin
          // Saturating count of stalled cycles; reaching the limit aborts.
          stall_nxt = (stall_r == STALL_LIM) ? stall_r : stall_r + SW'(1'b1);
          if (stall_nxt == STALL_LIM) begin
            err_nxt   = 1'b1;
            grant_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_FETCH;
          end
        end else begin
          stall_nxt = '0;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (!last_r) begin
            state_nxt = S_FETCH;
          end else begin
`ifdef UART_ARB_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            grant_nxt = '0;
            state_nxt = S_IDLE;
`endif
          end
        end else begin
          state_nxt = S_WAIT;
        end
      end
`ifdef UART_ARB_CHECKSUM_EN
      S_CSUM: begin
        tx_byte_nxt = csum_r;
        tx_dv_nxt   = 1'b1;
        state_nxt   = S_CWAIT;
      end
      S_CWAIT: begin
        if (tx_done) begin
          grant_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_CWAIT;
        end
      end
`endif
      default: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops everything back to idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      ptr_r     <= PTR_RST;
      grant_r   <= '0;
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      last_r    <= 1'b0;
      csum_r    <= 8'h00;
      stall_r   <= '0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      ptr_r     <= ptr_nxt;
      grant_r   <= grant_nxt;
      tx_dv_r   <= tx_dv_nxt;
      tx_byte_r <= tx_byte_nxt;
      last_r    <= last_nxt;
      csum_r    <= csum_nxt;
      stall_r   <= stall_nxt;
      busy_r    <= (state_nxt != S_IDLE);
      err_r     <= err_nxt;
    end
  end

  assign req_ready   = ready_s;
  assign tx_dv       = tx_dv_r;
  assign tx_byte     = tx_byte_r;
  assign grant       = grant_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule
